// File: rtl/paint_layer_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// paint_layer_fetch_scheduler
//
// Fetches the per-pixel sprite colour of up to N_LAYERS paint layers through a
// single shared sprite ROM read port, in painter priority order (index 0 first).
// As soon as a fetched layer is opaque the remaining lower-priority layers are
// reported transparent without touching the ROM. The assembled bundle is
// registered and presented to the pixel painter with a one-cycle out_valid_o.
//
// Ports
//   clk_i                 system clock
//   rst_i                 synchronous active-high reset
//   pixel_tick_i          one-cycle pulse starting a pixel slot
//   layer_hit_i           per-layer "beam inside sprite bbox", sampled on tick
//   layer_addr_i          per-layer ROM address (layer i at [i*ADDR_W +: ADDR_W])
//   rom_req_o             one-cycle ROM read strobe
//   rom_addr_o            ROM read address, valid with rom_req_o (0 otherwise)
//   rom_valid_i           ROM read data valid (latency >= 1)
//   rom_data_i            [12] transparency, [11:8] blue, [7:4] green, [3:0] red
//   layer_color_o         layer i at [i*12 +: 12]: red [3:0], green [7:4], blue [11:8]
//   layer_transparency_o  1 = layer not drawn at this pixel
//   out_valid_o           one-cycle pulse, new bundle presented
//   overrun_o             sticky: pixel_tick_i arrived while a fetch was running
//
// State     | meaning
// ----------+------------------------------------------------------------------
// S_IDLE    | waiting for pixel_tick_i; snapshot hits/addresses, clear bundle
// S_ISSUE   | strobe the ROM for the highest-priority pending layer
// S_WAIT    | wait for rom_valid_i; the final response publishes the bundle
//           | directly so data is visible one cycle after it returns
// S_DONE    | zero-hit pixel: publish the all-transparent bundle
// -----------------------------------------------------------------------------
module paint_layer_fetch_scheduler #(
   parameter int N_LAYERS = 4,
   parameter int ADDR_W   = 14
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         pixel_tick_i,
   input  logic [N_LAYERS-1:0]          layer_hit_i,
   input  logic [N_LAYERS*ADDR_W-1:0]   layer_addr_i,
   output logic                         rom_req_o,
   output logic [ADDR_W-1:0]            rom_addr_o,
   input  logic                         rom_valid_i,
   input  logic [12:0]                  rom_data_i,
   output logic [N_LAYERS*12-1:0]       layer_color_o,
   output logic [N_LAYERS-1:0]          layer_transparency_o,
   output logic                         out_valid_o,
   output logic                         overrun_o
);

   localparam int SEL_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                                state_q, state_d;
   logic [N_LAYERS-1:0]                   pend_q, pend_d;
   logic [SEL_W-1:0]                      sel_q, sel_d;
   logic [N_LAYERS-1:0][ADDR_W-1:0]       addr_q;
   logic [N_LAYERS-1:0][11:0]             work_col_q, work_col_d;
   logic [N_LAYERS-1:0]                   work_tr_q, work_tr_d;
   logic [N_LAYERS-1:0][11:0]             out_col_q;
   logic [N_LAYERS-1:0]                   out_tr_q;
   logic                                  out_valid_q;
   logic                                  overrun_q;

   logic [SEL_W-1:0]                      low_idx;
   logic                                  accept_tick;
   logic                                  load_out;
   logic                                  rom_req;

   assign accept_tick = (state_q == S_IDLE) && pixel_tick_i;

   // Highest-priority pending layer = lowest set bit of the pending mask.
   always_comb begin
      low_idx = '0;
      for (int i = N_LAYERS - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            low_idx = SEL_W'(i);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      sel_d      = sel_q;
      work_col_d = work_col_q;
      work_tr_d  = work_tr_q;
      load_out   = 1'b0;
      rom_req    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pixel_tick_i) begin
               pend_d     = layer_hit_i;
               work_col_d = '0;
               work_tr_d  = '1;
               state_d    = S_ISSUE;
            end
         end

         S_ISSUE: begin
            if (pend_q == '0) begin
               state_d = S_DONE;
            end else begin
               rom_req         = 1'b1;
               sel_d           = low_idx;
               pend_d[low_idx] = 1'b0;
               state_d         = S_WAIT;
            end
         end

         S_WAIT: begin
            if (rom_valid_i) begin
               work_col_d[sel_q] = rom_data_i[11:0];
               work_tr_d[sel_q]  = rom_data_i[12];
               if (!rom_data_i[12]) begin
                  // Opaque: everything below is hidden, skip its fetch.
                  pend_d   = '0;
                  load_out = 1'b1;
                  state_d  = S_IDLE;
               end else if (pend_q != '0) begin
                  state_d = S_ISSUE;
               end else begin
                  load_out = 1'b1;
                  state_d  = S_IDLE;
               end
            end
         end

         S_DONE: begin
            load_out = 1'b1;
            state_d  = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         pend_q      <= '0;
         sel_q       <= '0;
         addr_q      <= '0;
         work_col_q  <= '0;
         work_tr_q   <= '1;
         out_col_q   <= '0;
         out_tr_q    <= '1;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         sel_q       <= sel_d;
         work_col_q  <= work_col_d;
         work_tr_q   <= work_tr_d;
         out_valid_q <= load_out;
         if (accept_tick) begin
            addr_q <= layer_addr_i;
         end
         if (load_out) begin
            out_col_q <= work_col_d;
            out_tr_q  <= work_tr_d;
         end
         if (pixel_tick_i && (state_q != S_IDLE)) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign rom_req_o            = rom_req;
   assign rom_addr_o           = rom_req ? addr_q[low_idx] : '0;
   assign layer_color_o        = out_col_q;
   assign layer_transparency_o = out_tr_q;
   assign out_valid_o          = out_valid_q;
   assign overrun_o            = overrun_q;

endmodule

// File: tb/tb_paint_layer_fetch_scheduler.sv
module tb_paint_layer_fetch_scheduler;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        pixel_tick = 1'b0;
   logic [3:0]  layer_hit = '0;
   logic [55:0] layer_addr = '0;
   logic        rom_req;
   logic [13:0] rom_addr;
   logic        rom_valid = 1'b0;
   logic [12:0] rom_data = '0;
   logic [47:0] layer_color;
   logic [3:0]  layer_tr;
   logic        out_valid;
   logic        overrun;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   paint_layer_fetch_scheduler #(.N_LAYERS(4), .ADDR_W(14)) dut (
      .clk_i                (clk),
      .rst_i                (rst_i),
      .pixel_tick_i         (pixel_tick),
      .layer_hit_i          (layer_hit),
      .layer_addr_i         (layer_addr),
      .rom_req_o            (rom_req),
      .rom_addr_o           (rom_addr),
      .rom_valid_i          (rom_valid),
      .rom_data_i           (rom_data),
      .layer_color_o        (layer_color),
      .layer_transparency_o (layer_tr),
      .out_valid_o          (out_valid),
      .overrun_o            (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ROM model and event logs
   logic [12:0] rom_mem [logic [13:0]];
   int          rom_lat = 1;
   bit          resp_pend = 1'b0;
   int          resp_due = 0;
   logic [13:0] resp_addr = '0;

   int          req_cyc[$];
   logic [13:0] req_addr[$];
   int          ov_cyc[$];
   logic [3:0]  ov_tr[$];
   logic [47:0] ov_col[$];

   always @(negedge clk) begin
      rom_valid = 1'b0;
      rom_data  = 13'($urandom);
      if (resp_pend && cyc == resp_due) begin
         rom_valid = 1'b1;
         rom_data  = rom_mem.exists(resp_addr) ? rom_mem[resp_addr] : 13'h1FFF;
         resp_pend = 1'b0;
      end
      if (rom_req) begin
         req_cyc.push_back(cyc);
         req_addr.push_back(rom_addr);
         resp_pend = 1'b1;
         resp_due  = cyc + rom_lat;
         resp_addr = rom_addr;
      end
      if (out_valid) begin
         ov_cyc.push_back(cyc);
         ov_tr.push_back(layer_tr);
         ov_col.push_back(layer_color);
      end
   end

   task automatic clear_logs();
      req_cyc.delete();
      req_addr.delete();
      ov_cyc.delete();
      ov_tr.delete();
      ov_col.delete();
   endtask

   // One pixel slot: stimulus, reference model of the priority/early-out rule
   // and timing, then inline comparison of everything the DUT produced.
   task automatic run_pixel(input string name, input logic [3:0] hit,
                            input logic [3:0][13:0] addr, input logic [3:0][12:0] data,
                            input int lat, input int extra_tick, input bit exp_ovr);
      int         t0;
      int         k;
      int         exp_out;
      int         exp_idx[$];
      logic [3:0] exp_tr;
      logic [47:0] exp_col;
      bit         stop;
      exp_tr  = 4'hF;
      exp_col = '0;
      stop    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (hit[i] && !stop) begin
            exp_idx.push_back(i);
            exp_tr[i] = data[i][12];
            exp_col[i*12 +: 12] = data[i][11:0];
            if (!data[i][12]) stop = 1'b1;
         end
      end
      k = exp_idx.size();
      exp_out = (k == 0) ? 3 : 1 + k * (1 + lat);

      rom_lat = lat;
      for (int i = 0; i < 4; i++) rom_mem[addr[i]] = data[i];

      @(negedge clk);
      clear_logs();
      pixel_tick = 1'b1;
      layer_hit  = hit;
      layer_addr = addr;
      t0 = cyc;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         pixel_tick = (c == extra_tick);
         layer_hit  = 4'($urandom);
         layer_addr = 56'({$urandom, $urandom});
      end
      pixel_tick = 1'b0;

      n_cmp++;
      if (req_cyc.size() !== k) begin
         n_err++;
         $display("FAIL %s req_count: got %0d want %0d", name, req_cyc.size(), k);
      end
      for (int j = 0; j < k && j < req_cyc.size(); j++) begin
         n_cmp++;
         if (req_cyc[j] - t0 !== 1 + j * (1 + lat) || req_addr[j] !== addr[exp_idx[j]]) begin
            n_err++;
            $display("FAIL %s req%0d: got T+%0d addr %h want T+%0d addr %h", name, j,
                     req_cyc[j] - t0, req_addr[j], 1 + j * (1 + lat), addr[exp_idx[j]]);
         end
      end
      n_cmp++;
      if (ov_cyc.size() !== 1) begin
         n_err++;
         $display("FAIL %s out_valid_count: got %0d want 1", name, ov_cyc.size());
      end else begin
         n_cmp++;
         if (ov_cyc[0] - t0 !== exp_out) begin
            n_err++;
            $display("FAIL %s out_valid_time: got T+%0d want T+%0d", name, ov_cyc[0] - t0, exp_out);
         end
         n_cmp++;
         if (ov_tr[0] !== exp_tr) begin
            n_err++;
            $display("FAIL %s transparency: got %b want %b", name, ov_tr[0], exp_tr);
         end
         n_cmp++;
         if (ov_col[0] !== exp_col) begin
            n_err++;
            $display("FAIL %s colour: got %h want %h", name, ov_col[0], exp_col);
         end
      end
      n_cmp++;
      if (layer_tr !== exp_tr || layer_color !== exp_col) begin
         n_err++;
         $display("FAIL %s hold: got %b/%h want %b/%h", name, layer_tr, layer_color, exp_tr, exp_col);
      end
      n_cmp++;
      if (overrun !== exp_ovr) begin
         n_err++;
         $display("FAIL %s overrun: got %b want %b", name, overrun, exp_ovr);
      end
   endtask

   task automatic test_reset();
      clear_logs();
      rst_i = 1'b1;
      repeat (4) @(negedge clk);
      rst_i = 1'b0;
      repeat (20) @(negedge clk);
      n_cmp++;
      if (req_cyc.size() !== 0) begin
         n_err++;
         $display("FAIL reset rom_req_count: got %0d want 0", req_cyc.size());
      end
      n_cmp++;
      if (ov_cyc.size() !== 0) begin
         n_err++;
         $display("FAIL reset out_valid_count: got %0d want 0", ov_cyc.size());
      end
      n_cmp++;
      if (layer_tr !== 4'b1111) begin
         n_err++;
         $display("FAIL reset transparency: got %b want 1111", layer_tr);
      end
      n_cmp++;
      if (layer_color !== 48'h0) begin
         n_err++;
         $display("FAIL reset colour: got %h want 0", layer_color);
      end
      n_cmp++;
      if (overrun !== 1'b0 || rom_addr !== 14'h0) begin
         n_err++;
         $display("FAIL reset overrun_addr: got %b/%h want 0/0", overrun, rom_addr);
      end
   endtask

   task automatic test_no_hits();
      logic [3:0][13:0] a;
      logic [3:0][12:0] d;
      for (int i = 0; i < 4; i++) begin
         a[i] = 14'(i + 16);
         d[i] = 13'h0123;
      end
      run_pixel("no_hits", 4'b0000, a, d, 1, -1, 1'b0);
   endtask

   task automatic test_early_out();
      logic [3:0][13:0] a;
      logic [3:0][12:0] d;
      a[0] = 14'h0001; a[1] = 14'h0002; a[2] = 14'h0123; a[3] = 14'h0456;
      d[0] = 13'h1111; d[1] = 13'h1222; d[2] = 13'h0F80; d[3] = 13'h0ABC;
      run_pixel("early_out", 4'b1100, a, d, 1, -1, 1'b0);
   endtask

   task automatic test_fall_through();
      logic [3:0][13:0] a;
      logic [3:0][12:0] d;
      for (int i = 0; i < 3; i++) begin
         a[i] = 14'({$urandom_range(0, 4095), 2'(i)});
         d[i] = {1'b1, 12'($urandom)};
      end
      a[3] = 14'h3FF3;
      d[3] = 13'h0FFF;
      run_pixel("fall_through", 4'b1111, a, d, 1, -1, 1'b0);
   endtask

   task automatic test_random();
      logic [3:0][13:0] a;
      logic [3:0][12:0] d;
      string nm;
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < 4; i++) begin
            a[i] = 14'({$urandom_range(0, 4095), 2'(i)});
            d[i] = {1'($urandom_range(0, 1)), 12'($urandom)};
         end
         nm = $sformatf("random%0d", n);
         run_pixel(nm, 4'($urandom_range(0, 15)), a, d, $urandom_range(1, 3), -1, 1'b0);
      end
   endtask

   task automatic test_overrun();
      logic [3:0][13:0] a;
      logic [3:0][12:0] d;
      for (int i = 0; i < 4; i++) begin
         a[i] = 14'(14'h0100 + i);
         d[i] = {1'b1, 12'($urandom)};
      end
      d[3] = 13'h0FFF;
      run_pixel("overrun", 4'b1111, a, d, 1, 4, 1'b1);
      d[0] = 13'h0345;
      run_pixel("overrun_sticky", 4'b0011, a, d, 1, -1, 1'b1);
   endtask

   task automatic test_reset_mid_fetch();
      logic [3:0][13:0] a;
      logic [3:0][12:0] d;
      int t0;
      for (int i = 0; i < 4; i++) begin
         a[i] = 14'(14'h0200 + i);
         d[i] = {1'b1, 12'($urandom)};
      end
      rom_lat = 3;
      for (int i = 0; i < 4; i++) rom_mem[a[i]] = d[i];
      @(negedge clk);
      clear_logs();
      pixel_tick = 1'b1;
      layer_hit  = 4'b1111;
      layer_addr = a;
      t0 = cyc;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         pixel_tick = 1'b0;
         rst_i = (c == 2);
      end
      rst_i = 1'b0;
      n_cmp++;
      if (req_cyc.size() !== 1) begin
         n_err++;
         $display("FAIL rst_mid req_count: got %0d want 1", req_cyc.size());
      end else begin
         n_cmp++;
         if (req_cyc[0] - t0 !== 1) begin
            n_err++;
            $display("FAIL rst_mid req_time: got T+%0d want T+1", req_cyc[0] - t0);
         end
      end
      n_cmp++;
      if (ov_cyc.size() !== 0) begin
         n_err++;
         $display("FAIL rst_mid out_valid_count: got %0d want 0", ov_cyc.size());
      end
      n_cmp++;
      if (layer_tr !== 4'b1111 || layer_color !== 48'h0) begin
         n_err++;
         $display("FAIL rst_mid outputs: got %b/%h want 1111/0", layer_tr, layer_color);
      end
      n_cmp++;
      if (overrun !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid overrun: got %b want 0", overrun);
      end
      d[1] = 13'h0C3A;
      run_pixel("after_rst", 4'b0110, a, d, 1, -1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_no_hits();
      test_early_out();
      test_fall_through();
      test_random();
      test_overrun();
      test_reset_mid_fetch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
